desplazador_iterativo: RTL and testbench

Multi-cycle, parametrised shift unit for the RV32I datapath. It succeeds the combinational right shifter with a sequential design that supports left, right-logical, right-arithmetic and rotate modes. The datapath is one log-stage per cycle, so a single stage of muxes replaces the full barrel. It sits beside the ALU and is driven by the execute-stage control through a valid/ready handshake.

---
 rtl/desplazador_pkg.sv | 19 +
 rtl/fn_etapa_desp.sv | 36 +++
 rtl/desplazador_iterativo.sv | 103 ++++++++++
 tb/tb_desplazador_iterativo.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/desplazador_pkg.sv
// Shared encodings for the iterative shift unit: operation modes and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package desplazador_pkg;

    typedef enum logic [1:0] {
        MODO_SLL = 2'b00,
        MODO_SRL = 2'b01,
        MODO_SRA = 2'b10,
        MODO_ROR = 2'b11
    } modo_e;

    typedef enum logic [1:0] {
        LIBRE       = 2'b00,
        DESPLAZANDO = 2'b01,
        LISTO       = 2'b10
    } estado_e;

endpackage

// File: rtl/fn_etapa_desp.sv
// One log-stage of the shifter: shifts/rotates by 2^k when enabled, else passes through.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module fn_etapa_desp
    import desplazador_pkg::*;
#(
    parameter int ANCHO = 32,
    parameter int NB    = $clog2(ANCHO),
    parameter int KB    = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic [ANCHO-1:0] valor,
    input  logic [KB-1:0]    k,
    input  logic             en,
    input  modo_e            modo,
    output logic [ANCHO-1:0] resultado
);

    localparam logic [NB:0] ANCHO_W = (NB+1)'(ANCHO);

    // k never exceeds NB-1, so s <= ANCHO/2 and the rotate complement is always in range.
    logic [NB:0] s;
    assign s = (NB+1)'(1) << k;

    always_comb begin
        resultado = valor;
        if (en) begin
            case (modo)
                MODO_SLL: resultado = valor << s;
                MODO_SRL: resultado = valor >> s;
                MODO_SRA: resultado = $signed(valor) >>> s;
                default:  resultado = (valor >> s) | (valor << (ANCHO_W - s));
            endcase
        end
    end

endmodule

// File: rtl/desplazador_iterativo.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROR), one log-stage per cycle through a single reused stage.
// Latency: NB cycles from acceptance edge to sal_valido; result registered in Y.
// Backpressure: holds result in LISTO until sal_listo; ent_listo low whenever not idle.
module desplazador_iterativo
    import desplazador_pkg::*;
#(
    parameter int ANCHO = 32,
    parameter int NB    = $clog2(ANCHO)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ent_valido,
    output logic             ent_listo,
    input  logic [ANCHO-1:0] a,
    input  logic [NB-1:0]    b,
    input  logic [1:0]       modo,
    output logic             sal_valido,
    input  logic             sal_listo,
    output logic [ANCHO-1:0] Y
);

    localparam int KB = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [KB-1:0] K_ULTIMO = KB'(NB - 1);

    if ((ANCHO < 2) || ((ANCHO & (ANCHO - 1)) != 0)) begin : g_ancho_invalido
        $error("desplazador_iterativo: ANCHO must be a power of two >= 2");
    end

    estado_e          estado, estado_sig;
    logic [ANCHO-1:0] acumulador;
    logic [NB-1:0]    b_reg;
    modo_e            modo_reg;
    logic [KB-1:0]    k;
    logic [ANCHO-1:0] etapa;
    logic             ultimo;

    fn_etapa_desp #(
        .ANCHO (ANCHO),
        .NB    (NB),
        .KB    (KB)
    ) u_etapa (
        .valor     (acumulador),
        .k         (k),
        .en        (b_reg[k]),
        .modo      (modo_reg),
        .resultado (etapa)
    );

    assign ultimo     = (k == K_ULTIMO);
    assign ent_listo  = (estado == LIBRE) && !reset;
    assign sal_valido = (estado == LISTO);

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= LIBRE;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            LIBRE:       if (ent_valido) estado_sig = DESPLAZANDO;
            DESPLAZANDO: if (ultimo)     estado_sig = LISTO;
            LISTO:       if (sal_listo)  estado_sig = LIBRE;
            default:                     estado_sig = LIBRE;
        endcase
    end

    // Operands are captured only on acceptance, so later input changes cannot leak in.
    always_ff @(posedge clk) begin
        if (reset) begin
            acumulador <= '0;
            b_reg      <= '0;
            modo_reg   <= MODO_SLL;
            k          <= '0;
            Y          <= '0;
        end else begin
            case (estado)
                LIBRE: begin
                    if (ent_valido) begin
                        acumulador <= a;
                        b_reg      <= b;
                        modo_reg   <= modo_e'(modo);
                        k          <= '0;
                    end
                end
                DESPLAZANDO: begin
                    acumulador <= etapa;
                    if (ultimo) begin
                        k <= '0;
                        Y <= etapa;
                    end else begin
                        k <= k + KB'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_desplazador_iterativo.sv
// Bench for desplazador_iterativo: reference model from shift arithmetic plus directed vectors.
module tb_desplazador_iterativo;

    localparam int ANCHO = 32;
    localparam int NB    = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             ent_valido = 1'b0;
    logic             ent_listo;
    logic [ANCHO-1:0] a = '0;
    logic [NB-1:0]    b = '0;
    logic [1:0]       modo = 2'b00;
    logic             sal_valido;
    logic             sal_listo = 1'b1;
    logic [ANCHO-1:0] Y;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    desplazador_iterativo #(.ANCHO(ANCHO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ent_valido (ent_valido),
        .ent_listo  (ent_listo),
        .a          (a),
        .b          (b),
        .modo       (modo),
        .sal_valido (sal_valido),
        .sal_listo  (sal_listo),
        .Y          (Y)
    );

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] esp);
        n_cmp++;
        if (act !== esp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nombre, act, esp, $time);
        end
    endtask

    // Reference result straight from the arithmetic meaning of each mode.
    function automatic logic [31:0] ref_shift(input logic [31:0] va, input logic [4:0] vb,
                                              input logic [1:0] vm);
        logic [63:0] doble;
        logic [31:0] r;
        case (vm)
            2'b00: r = va << vb;
            2'b01: r = va >> vb;
            2'b10: r = $signed(va) >>> vb;
            default: begin
                doble = {va, va} >> vb;
                r = doble[31:0];
            end
        endcase
        return r;
    endfunction

    // Transaction-level model: an accepted op becomes visible NB edges later, until consumed.
    bit          m_ocupado = 1'b0;
    bit          m_listo   = 1'b0;
    int          m_cnt     = 0;
    logic [31:0] m_pend    = '0;
    logic [31:0] m_y       = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_ocupado = 1'b0;
            m_listo   = 1'b0;
            m_y       = '0;
        end else if (m_listo) begin
            if (sal_listo) m_listo = 1'b0;
        end else if (m_ocupado) begin
            m_cnt++;
            if (m_cnt == NB) begin
                m_ocupado = 1'b0;
                m_listo   = 1'b1;
                m_y       = m_pend;
            end
        end else if (ent_valido) begin
            m_ocupado = 1'b1;
            m_cnt     = 0;
            m_pend    = ref_shift(a, b, modo);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sal_valido", {31'b0, sal_valido}, {31'b0, m_listo});
            chk("ent_listo", {31'b0, ent_listo}, {31'b0, !m_ocupado && !m_listo && !reset});
            chk("Y", Y, m_y);
        end
    end

    task automatic paso();
        @(posedge clk);
        #1;
    endtask

    task automatic esperar_libre();
        int n = 0;
        while (!ent_listo && n < 30) begin
            paso();
            n++;
        end
        chk("espera ent_listo", {31'b0, ent_listo}, 32'd1);
    endtask

    // Issue one op, scramble inputs right after acceptance, check latency and literal result.
    task automatic run_op(input logic [31:0] va, input logic [4:0] vb, input logic [1:0] vm,
                          input logic [31:0] esp, input string nombre);
        int ciclos;
        esperar_libre();
        a = va; b = vb; modo = vm; ent_valido = 1'b1;
        paso();
        ent_valido = 1'b0;
        a = ~va; b = ~vb; modo = vm ^ 2'b01;
        ciclos = 0;
        while (!sal_valido && ciclos < 20) begin
            paso();
            ciclos++;
        end
        chk("latencia", ciclos, 32'd5);
        chk(nombre, Y, esp);
        paso();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        paso();
        chk_en = 1'b1;
        paso();
        chk("reset Y", Y, 32'h0);
        chk("reset sal_valido", {31'b0, sal_valido}, 32'd0);
        chk("reset ent_listo", {31'b0, ent_listo}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post reset ent_listo", {31'b0, ent_listo}, 32'd1);

        run_op(32'h80000000, 5'd0, 2'b01, 32'h80000000, "SRL b0");
        run_op(32'h80000000, 5'd1, 2'b01, 32'h40000000, "SRL b1");
        run_op(32'h80000000, 5'd2, 2'b01, 32'h20000000, "SRL b2");
        run_op(32'h80000000, 5'd3, 2'b01, 32'h10000000, "SRL b3");
        run_op(32'h80000000, 5'd4, 2'b01, 32'h08000000, "SRL b4");
        run_op(32'h80000000, 5'd0, 2'b10, 32'h80000000, "SRA b0");
        run_op(32'h80000000, 5'd1, 2'b10, 32'hC0000000, "SRA b1");
        run_op(32'h80000000, 5'd2, 2'b10, 32'hE0000000, "SRA b2");
        run_op(32'h80000000, 5'd3, 2'b10, 32'hF0000000, "SRA b3");
        run_op(32'h80000000, 5'd4, 2'b10, 32'hF8000000, "SRA b4");
        run_op(32'h7FFFFFFF, 5'd31, 2'b10, 32'h00000000, "SRA pos b31");
        run_op(32'h00000001, 5'd31, 2'b00, 32'h80000000, "SLL b31");
        run_op(32'h12345678, 5'd8, 2'b11, 32'h78123456, "ROR b8");
        run_op(32'h12345678, 5'd0, 2'b11, 32'h12345678, "ROR b0");
        run_op(32'h80000001, 5'd31, 2'b11, 32'h00000003, "ROR b31");
        run_op(32'hA5A5A5A5, 5'd13, 2'b00, 32'hB4B4A000, "SLL b13");

        // Backpressure: result held, new requests ignored while not consumed.
        esperar_libre();
        sal_listo = 1'b0;
        a = 32'h0000F000; b = 5'd12; modo = 2'b01; ent_valido = 1'b1;
        paso();
        a = 32'hFFFFFFFF; b = 5'd1; modo = 2'b00;
        for (int i = 0; i < NB; i++) paso();
        for (int i = 0; i < 10; i++) begin
            chk("bp Y", Y, 32'h0000000F);
            chk("bp sal_valido", {31'b0, sal_valido}, 32'd1);
            chk("bp ent_listo", {31'b0, ent_listo}, 32'd0);
            paso();
        end
        ent_valido = 1'b0;
        sal_listo  = 1'b1;
        paso();
        chk("release ent_listo", {31'b0, ent_listo}, 32'd1);
        chk("release Y kept", Y, 32'h0000000F);

        // Reset mid-operation discards the op and clears Y.
        a = 32'h12340000; b = 5'd16; modo = 2'b01; ent_valido = 1'b1;
        paso();
        ent_valido = 1'b0;
        paso();
        paso();
        reset = 1'b1;
        paso();
        chk("midreset sal_valido", {31'b0, sal_valido}, 32'd0);
        chk("midreset Y", Y, 32'h0);
        chk("midreset ent_listo", {31'b0, ent_listo}, 32'd0);
        reset = 1'b0;
        run_op(32'hF0000000, 5'd4, 2'b01, 32'h0F000000, "SRL after reset");

        paso();
        paso();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
